// File: rtl/number_format_converter.sv
// Bit-serial converter between two's complement and sign-magnitude.
// One magnitude bit per cycle, LSB first, with valid/ready handshakes on both sides.
module number_format_converter #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_ovf,
    output logic         out_negzero
);

    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           seen_q, seen_d;
    logic           mode_q, mode_d;
    logic [N-1:0]   src_q, src_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [N-1:0]   out_data_q, out_data_d;
    logic           ovf_q, ovf_d;
    logic           negzero_q, negzero_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           bit_in;
    logic           bit_out;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            seen_q      <= 1'b0;
            mode_q      <= 1'b0;
            src_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
            negzero_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seen_q      <= seen_d;
            mode_q      <= mode_d;
            src_q       <= src_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
            negzero_q   <= negzero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and serial conversion logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seen_d      = seen_q;
        mode_d      = mode_q;
        src_d       = src_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        ovf_d       = ovf_q;
        negzero_d   = negzero_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        bit_in      = src_q[cnt_q];
        bit_out     = bit_in;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d    = CONVERT;
                    src_d      = in_data;
                    mode_d     = mode;
                    acc_d      = {in_data[N-1], {(N-1){1'b0}}};
                    cnt_d      = '0;
                    seen_d     = 1'b0;
                    in_ready_d = 1'b0;
                end
            end
            CONVERT: begin
                // Negative operands: copy up to and including the first 1, invert above it
                bit_out        = (src_q[N-1] & seen_q) ? ~bit_in : bit_in;
                seen_d         = seen_q | bit_in;
                acc_d[cnt_q]   = bit_out;
                if (cnt_q == CW'(N - 2)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    if (src_q[N-1] && !seen_d) begin
                        out_data_d = mode_q ? '0 : '1;
                        ovf_d      = ~mode_q;
                        negzero_d  = mode_q;
                    end else begin
                        out_data_d = acc_d;
                        ovf_d      = 1'b0;
                        negzero_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_ovf     = ovf_q;
    assign out_negzero = negzero_q;

endmodule

// File: tb/tb_number_format_converter.sv
// Self-checking bench for number_format_converter: arithmetic reference model
// with per-cycle comparison, plus directed vectors with literal expectations.
module tb_number_format_converter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       mode = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_ovf;
    logic       out_negzero;

    logic       in4_valid = 1'b0;
    logic       in4_ready;
    logic       mode4 = 1'b0;
    logic [3:0] in4_data = 4'h0;
    logic       out4_valid;
    logic       out4_ready = 1'b1;
    logic [3:0] out4_data;
    logic       out4_ovf;
    logic       out4_negzero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    number_format_converter #(.N(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf), .out_negzero(out_negzero)
    );

    number_format_converter #(.N(4)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in4_valid), .in_ready(in4_ready),
        .mode(mode4), .in_data(in4_data),
        .out_valid(out4_valid), .out_ready(out4_ready),
        .out_data(out4_data), .out_ovf(out4_ovf), .out_negzero(out4_negzero)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference conversion by plain arithmetic: {ovf, negzero, data}
    function automatic logic [9:0] conv8(input logic m, input logic [7:0] x);
        int v;
        if (!m) begin
            v = int'($signed(x));
            if (v == -128) return {1'b1, 1'b0, 8'hFF};
            if (v < 0)     return {2'b00, 8'h80 | 8'(-v)};
            return {2'b00, x};
        end else begin
            if (x == 8'h80) return {1'b0, 1'b1, 8'h00};
            if (x[7])       return {2'b00, 8'(-int'(x[6:0]))};
            return {2'b00, x};
        end
    endfunction

    // Transaction-level model: latency countdown, handshakes, held result
    logic       m_ready = 1'b1;
    logic       m_valid = 1'b0;
    int         m_cnt = 0;
    logic [9:0] m_pend = '0;
    logic [9:0] m_res = '0;
    logic       chk_en = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_ready <= 1'b1;
            m_valid <= 1'b0;
            m_cnt   <= 0;
            m_res   <= '0;
        end else if (m_ready) begin
            if (in_valid) begin
                m_ready <= 1'b0;
                m_cnt   <= 7;
                m_pend  <= conv8(mode, in_data);
            end
        end else if (!m_valid) begin
            if (m_cnt == 1) begin
                m_valid <= 1'b1;
                m_res   <= m_pend;
            end
            m_cnt <= m_cnt - 1;
        end else if (out_ready) begin
            m_valid <= 1'b0;
            m_ready <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(m_ready));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_data", 32'(out_data), 32'(m_res[7:0]));
            chk("out_ovf", 32'(out_ovf), 32'(m_res[9]));
            chk("out_negzero", 32'(out_negzero), 32'(m_res[8]));
        end
    end

    // Caller is at a negedge; request is accepted on the next posedge
    task automatic run_req(input logic m, input logic [7:0] d, input logic [7:0] ed,
                           input logic eo, input logic en, input int hold);
        int lat;
        mode = m; in_data = d; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 8'h00;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'd7);
        chk("lit_data", 32'(out_data), 32'(ed));
        chk("lit_ovf", 32'(out_ovf), 32'(eo));
        chk("lit_negzero", 32'(out_negzero), 32'(en));
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0]; in_data = ~d; mode = ~m;
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(ed));
            chk("hold_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_ready", 32'(in_ready), 32'd1);
        chk("release_valid", 32'(out_valid), 32'd0);
    endtask

    localparam int NV = 11;
    logic       v_mode [NV] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] v_in   [NV] = '{8'hFB, 8'h80, 8'h80, 8'h85, 8'h35, 8'h35, 8'h00, 8'hFF, 8'h81, 8'h7F, 8'hC0};
    logic [7:0] v_out  [NV] = '{8'h85, 8'hFF, 8'h00, 8'hFB, 8'h35, 8'h35, 8'h00, 8'h81, 8'hFF, 8'h7F, 8'hC0};
    logic       v_ovf  [NV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       v_nz   [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        int lat;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_flags", 32'({out_ovf, out_negzero}), 32'd0);
        reset_n = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i < NV; i++)
            run_req(v_mode[i], v_in[i], v_out[i], v_ovf[i], v_nz[i], 0);

        // Result must hold while the consumer stalls
        run_req(1'b0, 8'hFB, 8'h85, 1'b0, 1'b0, 5);

        // Reset lands on the third CONVERT edge
        mode = 1'b0; in_data = 8'hFB; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("midrst_data", 32'(out_data), 32'd0);
        chk("midrst_flags", 32'({out_ovf, out_negzero}), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        run_req(1'b1, 8'h85, 8'hFB, 1'b0, 1'b0, 0);

        // N=4 instance
        mode4 = 1'b0; in4_data = 4'h9; in4_valid = 1'b1;
        @(negedge clk);
        in4_valid = 1'b0;
        lat = 0;
        while (!out4_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("n4_latency", 32'(lat), 32'd3);
        chk("n4_data", 32'(out4_data), 32'hF);
        chk("n4_ovf", 32'(out4_ovf), 32'd0);
        @(negedge clk);
        mode4 = 1'b1; in4_data = 4'h8; in4_valid = 1'b1;
        @(negedge clk);
        in4_valid = 1'b0;
        lat = 0;
        while (!out4_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("n4_nz_latency", 32'(lat), 32'd3);
        chk("n4_nz_data", 32'(out4_data), 32'h0);
        chk("n4_nz_flag", 32'(out4_negzero), 32'd1);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
